sc_datamem_io_bus: RTL and testbench

//  Parametrised data memory with memory-mapped I/O for the single-cycle CPU.

---
 rtl/sc_datamem_io_bus.sv | 123 ++++++++++++
 tb/tb_sc_datamem_io_bus.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sc_datamem_io_bus.sv
// Data memory with memory-mapped I/O for the single-cycle CPU: asynchronous-read RAM,
// registered output ports, synchronised input ports with change flags/IRQ and a cycle counter.
module sc_datamem_io_bus #(
   parameter int WIDTH       = 32,
   parameter int DEPTH_LOG2  = 5,
   parameter int N_IN        = 2,
   parameter int N_OUT       = 3,
   parameter int SYNC_STAGES = 2,
   parameter int IO_BIT      = 7
) (
   input  logic                   clock,
   input  logic                   resetn,
   input  logic                   we,
   input  logic [31:0]            addr,
   input  logic [WIDTH-1:0]       datain,
   input  logic [N_IN*WIDTH-1:0]  in_ports,
   output logic [WIDTH-1:0]       dataout,
   output logic [N_OUT*WIDTH-1:0] out_ports,
   output logic                   irq
);

   localparam logic [4:0] IDX_CHG_STATUS = 5'd16;
   localparam logic [4:0] IDX_CHG_MASK   = 5'd17;
   localparam logic [4:0] IDX_CYCLE_CNT  = 5'd18;
   localparam logic [4:0] IDX_IN_BASE    = 5'd8;

   logic                  w_io;
   logic [4:0]            w_idx;
   logic [DEPTH_LOG2-1:0] w_ram_idx;
   logic                  w_io_we;
   logic                  w_ram_we;
   logic                  w_unused_addr;

   assign w_io          = addr[IO_BIT];
   assign w_idx         = addr[6:2];
   assign w_ram_idx     = addr[DEPTH_LOG2+1:2];
   assign w_io_we       = we & w_io;
   assign w_ram_we      = we & ~w_io;
   assign w_unused_addr = ^addr;

   logic [WIDTH-1:0] r_mem [2**DEPTH_LOG2];

   // NOTE: the RAM array has no reset; its power-up contents are undefined by design.
   always_ff @(posedge clock) begin
      if (w_ram_we) r_mem[w_ram_idx] <= datain;
   end

   logic [WIDTH-1:0] r_sync [N_IN][SYNC_STAGES];
   logic [WIDTH-1:0] r_prev [N_IN];

   // Input synchroniser chain; r_prev is S delayed by one cycle for change detection.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         for (int i = 0; i < N_IN; i++) begin
            for (int s = 0; s < SYNC_STAGES; s++) r_sync[i][s] <= '0;
            r_prev[i] <= '0;
         end
      end else begin
         for (int i = 0; i < N_IN; i++) begin
            r_sync[i][0] <= in_ports[i*WIDTH +: WIDTH];
            for (int s = 1; s < SYNC_STAGES; s++) r_sync[i][s] <= r_sync[i][s-1];
            r_prev[i] <= r_sync[i][SYNC_STAGES-1];
         end
      end
   end

   logic [N_IN-1:0] w_chg_set;
   logic [N_IN-1:0] w_chg_clr;

   always_comb begin
      for (int i = 0; i < N_IN; i++) w_chg_set[i] = (r_sync[i][SYNC_STAGES-1] != r_prev[i]);
      w_chg_clr = (w_io_we && w_idx == IDX_CHG_STATUS) ? datain[N_IN-1:0] : '0;
   end

   logic [WIDTH-1:0] r_out [N_OUT];
   logic [N_IN-1:0]  r_chg_status;
   logic [N_IN-1:0]  r_chg_mask;
   logic [WIDTH-1:0] r_cycle_cnt;
   logic             r_irq;

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         for (int i = 0; i < N_OUT; i++) r_out[i] <= '0;
         r_chg_status <= '0;
         r_chg_mask   <= '0;
         r_cycle_cnt  <= '0;
         r_irq        <= 1'b0;
      end else begin
         for (int i = 0; i < N_OUT; i++) begin
            if (w_io_we && w_idx == 5'(i)) r_out[i] <= datain;
         end
         if (w_io_we && w_idx == IDX_CHG_MASK) r_chg_mask <= datain[N_IN-1:0];
         // Set has priority over a simultaneous W1C clear of the same bit.
         r_chg_status <= (r_chg_status & ~w_chg_clr) | w_chg_set;
         r_irq        <= |(r_chg_status & r_chg_mask);
         r_cycle_cnt  <= r_cycle_cnt + WIDTH'(1);
      end
   end

   always_comb begin
      for (int i = 0; i < N_OUT; i++) out_ports[i*WIDTH +: WIDTH] = r_out[i];
   end

   assign irq = r_irq;

   logic [WIDTH-1:0] w_rd_io;

   // NOTE: default assignment first so every path drives w_rd_io and no latch is inferred.
   always_comb begin
      w_rd_io = '0;
      for (int i = 0; i < N_OUT; i++) begin
         if (w_idx == 5'(i)) w_rd_io = r_out[i];
      end
      for (int i = 0; i < N_IN; i++) begin
         if (w_idx == IDX_IN_BASE + 5'(i)) w_rd_io = r_sync[i][SYNC_STAGES-1];
      end
      if (w_idx == IDX_CHG_STATUS) w_rd_io[N_IN-1:0] = r_chg_status;
      if (w_idx == IDX_CHG_MASK)   w_rd_io[N_IN-1:0] = r_chg_mask;
      if (w_idx == IDX_CYCLE_CNT)  w_rd_io = r_cycle_cnt;
      dataout = w_io ? w_rd_io : r_mem[w_ram_idx];
   end

endmodule

// File: tb/tb_sc_datamem_io_bus.sv
// Scoreboard bench for sc_datamem_io_bus: expected load values are queued as
// stimulus is driven and popped when the load data is sampled.
module tb_sc_datamem_io_bus;

   logic        clock;
   logic        resetn;
   logic        we;
   logic [31:0] addr;
   logic [31:0] datain;
   logic [63:0] in_ports;
   logic [31:0] dataout;
   logic [95:0] out_ports;
   logic        irq;

   logic        resetn8;
   logic        we8;
   logic [31:0] addr8;
   logic [7:0]  datain8;
   logic [15:0] in_ports8;
   logic [7:0]  dataout8;
   logic [23:0] out_ports8;
   logic        irq8;

   int n_cmp = 0;
   int n_err = 0;

   typedef struct {
      logic [31:0] a;
      logic [31:0] exp;
      string       name;
   } sb_t;

   sb_t sb_q[$];

   sc_datamem_io_bus dut (
      .clock(clock), .resetn(resetn), .we(we), .addr(addr), .datain(datain),
      .in_ports(in_ports), .dataout(dataout), .out_ports(out_ports), .irq(irq)
   );

   sc_datamem_io_bus #(.WIDTH(8)) dut8 (
      .clock(clock), .resetn(resetn8), .we(we8), .addr(addr8), .datain(datain8),
      .in_ports(in_ports8), .dataout(dataout8), .out_ports(out_ports8), .irq(irq8)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d);
      addr   = a;
      datain = d;
      we     = 1'b1;
      tick();
      we     = 1'b0;
   endtask

   task automatic rd(input logic [31:0] a, output logic [31:0] d);
      addr = a;
      #1;
      d = dataout;
   endtask

   task automatic expect_load(input logic [31:0] a, input logic [31:0] exp, input string name);
      sb_t e;
      e.a = a; e.exp = exp; e.name = name;
      sb_q.push_back(e);
   endtask

   task automatic test_reset();
      sb_t e;
      logic [31:0] got;
      resetn = 1'b0;
      #3;
      expect_load(32'h80, 32'h0, "rst_out0");
      expect_load(32'h84, 32'h0, "rst_out1");
      expect_load(32'h88, 32'h0, "rst_out2");
      expect_load(32'hC0, 32'h0, "rst_chg_status");
      expect_load(32'hC4, 32'h0, "rst_chg_mask");
      expect_load(32'hC8, 32'h0, "rst_cycle_cnt");
      while (sb_q.size() != 0) begin
         e = sb_q.pop_front();
         rd(e.a, got);
         n_cmp++;
         if (got !== e.exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", e.name, got, e.exp);
         end
      end
      n_cmp++;
      if (out_ports !== 96'h0) begin
         n_err++;
         $display("FAIL rst_out_ports: got %h expected 0", out_ports);
      end
      n_cmp++;
      if (irq !== 1'b0) begin
         n_err++;
         $display("FAIL rst_irq: got %b expected 0", irq);
      end
      tick();
      resetn = 1'b1;
   endtask

   task automatic test_ram();
      sb_t e;
      logic [31:0] got;
      wr(32'h04, 32'hDEADBEEF);
      expect_load(32'h04, 32'hDEADBEEF, "ram_04");
      wr(32'h7C, 32'h12345678);
      expect_load(32'h7C, 32'h12345678, "ram_7c");
      expect_load(32'h84, 32'h0, "ram_no_alias_out1");
      while (sb_q.size() != 0) begin
         e = sb_q.pop_front();
         rd(e.a, got);
         n_cmp++;
         if (got !== e.exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", e.name, got, e.exp);
         end
      end
   endtask

   task automatic test_out_ports();
      sb_t e;
      logic [31:0] got;
      wr(32'h80, 32'hA5A5A5A5);
      n_cmp++;
      if (out_ports[31:0] !== 32'hA5A5A5A5) begin
         n_err++;
         $display("FAIL out0_port: got %h expected a5a5a5a5", out_ports[31:0]);
      end
      n_cmp++;
      if (out_ports[95:32] !== 64'h0) begin
         n_err++;
         $display("FAIL out12_port: got %h expected 0", out_ports[95:32]);
      end
      wr(32'h88, 32'h0000_0C3C);
      wr(32'hA0, 32'hFFFFFFFF);
      wr(32'hCC, 32'hFFFFFFFF);
      expect_load(32'h80, 32'hA5A5A5A5, "out0_readback");
      expect_load(32'h88, 32'h0000_0C3C, "out2_readback");
      expect_load(32'hA0, 32'h0, "in0_write_ignored");
      expect_load(32'hCC, 32'h0, "unmapped_reads_0");
      expect_load(32'h8C, 32'h0, "out3_unmapped");
      expect_load(32'hC0, 32'h0, "chg_status_quiet");
      while (sb_q.size() != 0) begin
         e = sb_q.pop_front();
         rd(e.a, got);
         n_cmp++;
         if (got !== e.exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", e.name, got, e.exp);
         end
      end
   endtask

   task automatic test_sync_change();
      sb_t e;
      logic [31:0] got;
      wr(32'hC4, 32'h1);
      in_ports[31:0] = 32'h55;
      expect_load(32'hA0, 32'h0, "sync_edge0");
      e = sb_q.pop_front(); rd(e.a, got); n_cmp++;
      if (got !== e.exp) begin n_err++; $display("FAIL %s: got %h expected %h", e.name, got, e.exp); end
      tick();
      expect_load(32'hA0, 32'h0, "sync_edge1");
      e = sb_q.pop_front(); rd(e.a, got); n_cmp++;
      if (got !== e.exp) begin n_err++; $display("FAIL %s: got %h expected %h", e.name, got, e.exp); end
      tick();
      expect_load(32'hA0, 32'h55, "sync_edge2");
      expect_load(32'hC0, 32'h0, "chg_not_yet");
      expect_load(32'hC4, 32'h1, "mask_readback");
      while (sb_q.size() != 0) begin
         e = sb_q.pop_front(); rd(e.a, got); n_cmp++;
         if (got !== e.exp) begin n_err++; $display("FAIL %s: got %h expected %h", e.name, got, e.exp); end
      end
      tick();
      expect_load(32'hC0, 32'h1, "chg_set");
      e = sb_q.pop_front(); rd(e.a, got); n_cmp++;
      if (got !== e.exp) begin n_err++; $display("FAIL %s: got %h expected %h", e.name, got, e.exp); end
      n_cmp++;
      if (irq !== 1'b0) begin n_err++; $display("FAIL irq_early: got %b expected 0", irq); end
      tick();
      n_cmp++;
      if (irq !== 1'b1) begin n_err++; $display("FAIL irq_rise: got %b expected 1", irq); end
   endtask

   task automatic test_w1c();
      sb_t e;
      logic [31:0] got;
      in_ports[31:0] = 32'hAA;
      tick();
      tick();
      // S now differs from P: the clear lands on the same edge as a new set.
      wr(32'hC0, 32'h1);
      expect_load(32'hC0, 32'h1, "w1c_set_wins");
      e = sb_q.pop_front(); rd(e.a, got); n_cmp++;
      if (got !== e.exp) begin n_err++; $display("FAIL %s: got %h expected %h", e.name, got, e.exp); end
      wr(32'hC0, 32'h1);
      expect_load(32'hC0, 32'h0, "w1c_clear");
      e = sb_q.pop_front(); rd(e.a, got); n_cmp++;
      if (got !== e.exp) begin n_err++; $display("FAIL %s: got %h expected %h", e.name, got, e.exp); end
      n_cmp++;
      if (irq !== 1'b1) begin n_err++; $display("FAIL irq_hold: got %b expected 1", irq); end
      tick();
      n_cmp++;
      if (irq !== 1'b0) begin n_err++; $display("FAIL irq_fall: got %b expected 0", irq); end
   endtask

   task automatic test_cycle_cnt();
      sb_t e;
      logic [31:0] got;
      resetn = 1'b0;
      tick();
      resetn = 1'b1;
      expect_load(32'hC8, 32'd0, "cnt_start");
      e = sb_q.pop_front(); rd(e.a, got); n_cmp++;
      if (got !== e.exp) begin n_err++; $display("FAIL %s: got %h expected %h", e.name, got, e.exp); end
      repeat (5) tick();
      wr(32'hC8, 32'hFFFF0000);
      expect_load(32'hC8, 32'd6, "cnt_after_6_not_writable");
      e = sb_q.pop_front(); rd(e.a, got); n_cmp++;
      if (got !== e.exp) begin n_err++; $display("FAIL %s: got %h expected %h", e.name, got, e.exp); end
      repeat (3) tick();
      resetn = 1'b0;
      expect_load(32'hC8, 32'd0, "cnt_async_reset");
      e = sb_q.pop_front(); rd(e.a, got); n_cmp++;
      if (got !== e.exp) begin n_err++; $display("FAIL %s: got %h expected %h", e.name, got, e.exp); end
      n_cmp++;
      if (out_ports !== 96'h0) begin n_err++; $display("FAIL midreset_out_ports: got %h expected 0", out_ports); end
      tick();
      resetn = 1'b1;
   endtask

   task automatic test_wrap8();
      sb_t e;
      logic [31:0] got;
      resetn8 = 1'b0;
      tick();
      resetn8 = 1'b1;
      repeat (255) tick();
      addr8 = 32'hC8;
      expect_load(32'hC8, 32'hFF, "cnt8_all_ones");
      #1;
      e = sb_q.pop_front(); got = {24'h0, dataout8}; n_cmp++;
      if (got !== e.exp) begin n_err++; $display("FAIL %s: got %h expected %h", e.name, got, e.exp); end
      tick();
      expect_load(32'hC8, 32'h00, "cnt8_wrap");
      e = sb_q.pop_front(); got = {24'h0, dataout8}; n_cmp++;
      if (got !== e.exp) begin n_err++; $display("FAIL %s: got %h expected %h", e.name, got, e.exp); end
   endtask

   initial begin
      resetn    = 1'b0;
      we        = 1'b0;
      addr      = '0;
      datain    = '0;
      in_ports  = '0;
      resetn8   = 1'b0;
      we8       = 1'b0;
      addr8     = '0;
      datain8   = '0;
      in_ports8 = '0;
      test_reset();
      test_ram();
      test_out_ports();
      test_sync_change();
      test_w1c();
      test_cycle_cnt();
      test_wrap8();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
